// File: rtl/trace_capture.sv
// Circular trace buffer: records samples while armed and freezes a post-trigger window for random-access readout.
// Latency: a sample is visible to reads the cycle after its write; rd_data follows rd_addr by one clock.
// Backpressure: none; cap_valid is never stalled, and samples are dropped outside ARMED/POST. Optional data comparator: TRACE_CAPTURE_COMPARE_EN.
module trace_capture #(
    parameter  int DATA_W = 36,
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              cap_valid,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              trigger,
    input  logic [ADDR_W-1:0] post_count,
    output logic              armed,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] trig_pos,
`ifdef TRACE_CAPTURE_COMPARE_EN
    input  logic [DATA_W-1:0] cmp_value,
    input  logic [DATA_W-1:0] cmp_mask,
`endif
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] trig_ptr;
    logic [ADDR_W-1:0] remaining;
    logic              trig_eff;
    logic              wr_en;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] rd_phys;
    logic [DATA_W-1:0] rd_raw;
    logic              rd_vld;

    logic [DATA_W-1:0] mem [DEPTH];

`ifdef TRACE_CAPTURE_COMPARE_EN
    logic int_trig;
    assign int_trig = cap_valid && ((cap_data & cmp_mask) == (cmp_value & cmp_mask))
                      && (cmp_mask != '0);
    assign trig_eff = trigger || int_trig;
`else
    assign trig_eff = trigger;
`endif

    assign wr_en = !reset && !arm && cap_valid && (state == ST_ARMED || state == ST_POST);

    // Once the buffer has wrapped, the oldest entry sits at the write pointer.
    assign base     = (count == COUNT_FULL) ? wr_ptr : '0;
    assign rd_phys  = base + rd_addr;
    assign trig_pos = trig_ptr - base;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            count     <= '0;
            trig_ptr  <= '0;
            remaining <= '0;
            armed     <= 1'b0;
            done      <= 1'b0;
        end else if (arm) begin
            state     <= ST_ARMED;
            wr_ptr    <= '0;
            count     <= '0;
            trig_ptr  <= '0;
            remaining <= '0;
            armed     <= 1'b1;
            done      <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                if (count != COUNT_FULL)
                    count <= count + (ADDR_W+1)'(1);
            end
            case (state)
                ST_ARMED: begin
                    if (cap_valid && trig_eff) begin
                        trig_ptr  <= wr_ptr;
                        remaining <= post_count;
                        if (post_count == '0) begin
                            state <= ST_DONE;
                            armed <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (cap_valid) begin
                        remaining <= remaining - ADDR_W'(1);
                        if (remaining == ADDR_W'(1)) begin
                            state <= ST_DONE;
                            armed <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM kept free of reset so it maps onto a simple dual-port block RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= cap_data;
        rd_raw <= mem[rd_phys];
    end

    always_ff @(posedge clk) begin
        if (reset)
            rd_vld <= 1'b0;
        else
            rd_vld <= ({1'b0, rd_addr} < count);
    end

    assign rd_data = rd_vld ? rd_raw : '0;

endmodule
